// File: rtl/fifo_driver.sv
// fifo_driver: self-test sequencer that streams a seed-based pattern into a
// FIFO, reads it back, and tallies correct and erroneous responses.
module fifo_driver #(
    parameter int FIFO_WIDTH = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            num_words,
    input  logic [FIFO_WIDTH-1:0] seed,
    input  logic                  full,
    input  logic                  empty,
    input  logic                  wr_ack,
    input  logic                  overflow,
    input  logic                  underflow,
    input  logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [15:0]           correct_count,
    output logic [15:0]           error_count
);

    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            num_q;
    logic [FIFO_WIDTH-1:0] seed_q;
    logic [7:0]            wr_idx;
    logic [7:0]            rd_idx;
    logic [STALL_W-1:0]    stall_cnt;
    logic                  wr_pend;
    logic                  rd_pend;
    logic [FIFO_WIDTH-1:0] rd_exp;
    logic                  wr_last;
    logic                  rd_last;
    logic                  accept;
    logic [1:0]            ok_inc;
    logic [1:0]            bad_inc;

    function automatic logic [15:0] sat_add(input logic [15:0] a,
                                            input logic [1:0]  b);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign accept  = (state == IDLE) && start;
    assign data_in = seed_q + FIFO_WIDTH'(wr_idx);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, FIFO requests and status outputs
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        wr_last   = 1'b0;
        rd_last   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_words == 8'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                wr_en   = !full && (wr_idx < num_q);
                rd_en   = !empty && (rd_idx < num_q);
                wr_last = (wr_idx == num_q) ||
                          (wr_en && (wr_idx + 8'd1 == num_q));
                rd_last = (rd_idx == num_q) ||
                          (rd_en && (rd_idx + 8'd1 == num_q));
                if (wr_last && rd_last) begin
                    state_nxt = FLUSH;
                end else if (!wr_en && !rd_en &&
                             stall_cnt == STALL_LAST) begin
                    state_nxt = DONE;
                end
            end
            FLUSH: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Score the responses to last cycle's write and read
    always_comb begin
        ok_inc  = 2'd0;
        bad_inc = 2'd0;
        if (wr_pend) begin
            if (wr_ack && !overflow) begin
                ok_inc = ok_inc + 2'd1;
            end else begin
                bad_inc = bad_inc + 2'd1;
            end
        end
        if (rd_pend) begin
            if (!underflow && data_out == rd_exp) begin
                ok_inc = ok_inc + 2'd1;
            end else begin
                bad_inc = bad_inc + 2'd1;
            end
        end
    end

    // Run context, indices, stall watchdog and check counters
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q         <= '0;
            seed_q        <= '0;
            wr_idx        <= '0;
            rd_idx        <= '0;
            stall_cnt     <= '0;
            wr_pend       <= 1'b0;
            rd_pend       <= 1'b0;
            rd_exp        <= '0;
            timeout       <= 1'b0;
            correct_count <= '0;
            error_count   <= '0;
        end else if (accept) begin
            num_q         <= num_words;
            seed_q        <= seed;
            wr_idx        <= '0;
            rd_idx        <= '0;
            stall_cnt     <= '0;
            wr_pend       <= 1'b0;
            rd_pend       <= 1'b0;
            timeout       <= 1'b0;
            correct_count <= '0;
            error_count   <= '0;
        end else begin
            if (wr_en) begin
                wr_idx <= wr_idx + 8'd1;
            end
            if (rd_en) begin
                rd_idx <= rd_idx + 8'd1;
            end
            if (state == RUN) begin
                if (wr_en || rd_en) begin
                    stall_cnt <= '0;
                end else begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
                if (state_nxt == DONE) begin
                    timeout <= 1'b1;
                end
            end
            wr_pend       <= wr_en;
            rd_pend       <= rd_en;
            rd_exp        <= seed_q + FIFO_WIDTH'(rd_idx);
            correct_count <= sat_add(correct_count, ok_inc);
            error_count   <= sat_add(error_count, bad_inc);
        end
    end

endmodule

// File: doc/fifo_driver.md
FIFO_DRIVER -- requirements
Module: fifo_driver

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 16, the FIFO data width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, the maximum number of RUN cycles allowed without any progress.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1: sole clock; all logic is on the rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset, dominant over all other inputs.
REQ-006 Port start, input, 1: one-cycle request to begin a test run; honoured only in IDLE.
REQ-007 Port num_words, input, 8: number of words to write and read back; sampled when start is accepted.
REQ-008 Port seed, input, FIFO_WIDTH: base of the data pattern; sampled when start is accepted.
REQ-009 Port full / empty, input, 1 each: FIFO status flags.
REQ-010 Port wr_ack / overflow / underflow, input, 1 each: FIFO responses, registered one cycle after the request.
REQ-011 Port data_out, input, FIFO_WIDTH: FIFO read data, valid one cycle after an accepted rd_en.
REQ-012 Port wr_en / rd_en, output, 1 each: FIFO write and read requests.
REQ-013 Port data_in, output, FIFO_WIDTH: FIFO write data.
REQ-014 Port busy, output, 1: high in RUN and FLUSH.
REQ-015 Port done, output, 1: one-cycle pulse at the end of a run.
REQ-016 Port timeout, output, 1: sticky; set when a run aborts on stall.
REQ-017 Port correct_count / error_count, output, 16 each: run check counters.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, RUN, FLUSH and DONE.
REQ-019 In IDLE, start=1 SHALL capture num_words and seed, clear wr_idx, rd_idx, both counters and timeout, then go to RUN; if num_words=0 it SHALL go to DONE instead.
REQ-020 In RUN, wr_en SHALL be 1 iff !full and wr_idx<num_words.
REQ-021 data_in SHALL equal seed+wr_idx, truncated modulo 2^FIFO_WIDTH.
REQ-022 wr_idx SHALL increment on every cycle in which wr_en=1.
REQ-023 In RUN, rd_en SHALL be 1 iff !empty and rd_idx<num_words; rd_idx SHALL increment on every cycle in which rd_en=1.
REQ-024 Write and read MAY both be issued in the same cycle.
REQ-025 For each write issued at cycle t, wr_ack=1 at t+1 SHALL increment correct_count; otherwise, or if overflow=1, it SHALL increment error_count once.
REQ-026 For each read issued at cycle t with index k, data_out at t+1 SHALL be compared with seed+k; a match SHALL increment correct_count, and a mismatch or underflow=1 SHALL increment error_count once.
REQ-027 When one write check and one read check complete in the same cycle, both SHALL be counted; a counter can therefore rise by 2 in one cycle.
REQ-028 correct_count and error_count SHALL saturate at 16'hFFFF.
REQ-029 RUN SHALL go to FLUSH in the cycle after the last write and the last read have both been issued.
REQ-030 FLUSH SHALL last exactly one cycle, for the final checks, and then go to DONE.
REQ-031 In RUN, a stall counter SHALL clear on any issued write or read and otherwise increment; on reaching TIMEOUT, timeout SHALL be set and the FSM SHALL go to DONE.
REQ-032 DONE SHALL assert done for one cycle and then return to IDLE; the counters and timeout SHALL hold until the next accepted start.
REQ-033 start received outside IDLE SHALL be ignored.
REQ-034 wr_en and rd_en SHALL be 0 in IDLE, FLUSH and DONE.

Reset
REQ-035 On rst=1 at a clock edge, the FSM SHALL enter IDLE, and wr_en, rd_en, busy, done and timeout SHALL be 0.
REQ-036 On reset, data_in, correct_count, error_count, wr_idx, rd_idx and the stall counter SHALL be 0.
REQ-037 Reset in the middle of a run SHALL abort the run immediately, with no done pulse.

Verification
REQ-038 Scenario: behavioural 8-deep FIFO, seed=16'h1000, num_words=20 -> data_in 1000h..1013h, correct_count=40, error_count=0, one done pulse, timeout=0.
REQ-039 Scenario: full held at 1 and empty held at 1 after start -> no wr_en or rd_en, timeout=1 and done after 64 RUN cycles.
REQ-040 Scenario: FIFO model corrupts the 3rd read word, num_words=5 -> correct_count=9, error_count=1.
REQ-041 Scenario: start with num_words=0 -> done the next cycle, counters 0, no wr_en or rd_en.
REQ-042 Scenario: rst asserted mid-RUN with num_words=100 -> next cycle all outputs 0, FSM in IDLE, a new start runs cleanly.
REQ-043 Scenario: start pulsed while busy -> ignored, and the current run's counts are unchanged.
